// File: rtl/program_counter_stack_pkg.sv
// Shared word-size defaults and the per-cycle operation decode for the
// program counter with return-address stack.
package program_counter_stack_pkg;

  localparam int HACK_WORD_WIDTH   = 16;
  localparam int HACK_RESET_VECTOR = 0;
  localparam int HACK_DEPTH        = 8;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } op_e;

  // Only the highest-priority request in a cycle takes effect.
  function automatic op_e decode_op(input logic call, input logic ret,
                                    input logic load, input logic inc);
    if (call)      return OP_CALL;
    else if (ret)  return OP_RET;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Control/status bundle between the fetch sequencer (master) and the
// program counter (slave).
interface program_counter_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             inc;
  logic             load;
  logic             call;
  logic             ret;
  logic             clear_err;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  modport master (
    output inc, load, call, ret, clear_err, in,
    input  out, depth, overflow, underflow
  );

  modport slave (
    input  inc, load, call, ret, clear_err, in,
    output out, depth, overflow, underflow
  );
endinterface

// File: rtl/program_counter_stack_return_stack.sv
// Circular LIFO of return addresses. A push when full overwrites the oldest
// entry; rd_data always shows the current top of stack.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_q, top_d, top_p1, top_m1;
  logic [DW-1:0]    depth_q, depth_d;

  assign top_p1  = (top_q == PW'(DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_m1  = (top_q == '0) ? PW'(DEPTH - 1) : top_q - 1'b1;
  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign rd_data = mem_q[top_m1];

  // NOTE: every variable gets a default before the branches, so no latch is inferred.
  always_comb begin
    top_d   = top_q;
    depth_d = depth_q;
    if (push) begin
      top_d = top_p1;
      if (!full) depth_d = depth_q + 1'b1;
    end else if (pop && !empty) begin
      top_d   = top_m1;
      depth_d = depth_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q   <= '0;
      depth_q <= '0;
    end else begin
      top_q   <= top_d;
      depth_q <= depth_d;
    end
  end

  // NOTE: storage has no reset; entries are only read when depth shows them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[top_q] <= wr_data;
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with single-cycle call/return through a hardware
// return-address stack, plus sticky overflow/underflow error flags.
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int              WIDTH        = HACK_WORD_WIDTH,
  parameter int              DEPTH        = HACK_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(HACK_RESET_VECTOR)
) (
  input  logic                   clk,
  input  logic                   reset,
  program_counter_stack_if.slave bus
);
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push, pop, ovf_err, unf_err;
  logic             full, empty;
  logic [WIDTH-1:0] rd_data;
  op_e              op;

  // The pushed return address wraps modulo 2^WIDTH, same as inc.
  assign pc_inc = pc_q + 1'b1;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_return_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (pc_inc),
    .rd_data (rd_data),
    .depth   (bus.depth),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    op      = decode_op(bus.call, bus.ret, bus.load, bus.inc);
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_err = 1'b0;
    unf_err = 1'b0;
    case (op)
      OP_CALL: begin
        push    = 1'b1;
        pc_d    = bus.in;
        ovf_err = full;
      end
      OP_RET: begin
        if (empty) begin
          unf_err = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = rd_data;
        end
      end
      OP_LOAD: pc_d = bus.in;
      OP_INC:  pc_d = pc_inc;
      default: ;
    endcase
    // A new error in the same cycle as clear_err keeps the flag set.
    overflow_d  = (overflow_q  & ~bus.clear_err) | ovf_err;
    underflow_d = (underflow_q & ~bus.clear_err) | unf_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.out       = pc_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (WIDTH=16, DEPTH=8, RESET_VECTOR=0)
// with hand-computed expected values.
module tb_program_counter_stack;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  program_counter_stack_if #(.WIDTH(16), .DEPTH(8)) bus ();

  program_counter_stack #(
    .WIDTH        (16),
    .DEPTH        (8),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic l,
                       input logic i, input logic ce, input logic [15:0] d);
    bus.call      = c;
    bus.ret       = r;
    bus.load      = l;
    bus.inc       = i;
    bus.clear_err = ce;
    bus.in        = d;
  endtask

  // Inputs change 1 ns after an edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 16'h0000);
    #3;
    check("rst_out",       32'(bus.out),       32'h0000);
    check("rst_depth",     32'(bus.depth),     32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ret on an empty stack: out holds, underflow set
    drive(0, 1, 0, 0, 0, 16'h0000); tick();
    check("ret_empty_out",   32'(bus.out),       32'h0000);
    check("ret_empty_unf",   32'(bus.underflow), 32'd1);
    check("ret_empty_depth", 32'(bus.depth),     32'd0);

    // inc wrap, load, hold
    drive(0, 0, 1, 0, 0, 16'hFFFF); tick();
    drive(0, 0, 0, 1, 0, 16'h0000); tick();
    check("inc_wrap", 32'(bus.out), 32'h0000);
    drive(0, 0, 1, 0, 0, 16'h0ABC); tick();
    check("load", 32'(bus.out), 32'h0ABC);
    drive(0, 0, 0, 0, 0, 16'h5A5A); tick();
    check("hold", 32'(bus.out), 32'h0ABC);

    // simple call / ret
    drive(0, 0, 1, 0, 0, 16'h0010); tick();
    drive(1, 0, 0, 0, 0, 16'h0200); tick();
    check("call_out",   32'(bus.out),   32'h0200);
    check("call_depth", 32'(bus.depth), 32'd1);
    drive(0, 1, 0, 0, 0, 16'h0000); tick();
    check("ret_out",   32'(bus.out),   32'h0011);
    check("ret_depth", 32'(bus.depth), 32'd0);

    // reset mid-run, with a call pending: clears immediately, call not committed
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 16'h1234); tick();
    end
    check("pre_rst_out",   32'(bus.out),   32'h1234);
    check("pre_rst_depth", 32'(bus.depth), 32'd3);
    drive(1, 0, 0, 0, 0, 16'h5555);
    reset = 1'b1;
    #2;
    check("async_rst_out",   32'(bus.out),       32'h0000);
    check("async_rst_depth", 32'(bus.depth),     32'd0);
    check("async_rst_unf",   32'(bus.underflow), 32'd0);
    check("async_rst_ovf",   32'(bus.overflow),  32'd0);
    tick();
    check("rst_held_out",   32'(bus.out),   32'h0000);
    check("rst_held_depth", 32'(bus.depth), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 16'h0000);
    reset = 1'b0;
    tick();

    // 9 nested calls into an 8-deep stack
    drive(0, 0, 1, 0, 0, 16'h0100); tick();
    for (int k = 1; k <= 9; k++) begin
      drive(1, 0, 0, 0, 0, 16'((k + 1) << 8)); tick();
      check("nest_depth", 32'(bus.depth), (k < 8) ? 32'(k) : 32'd8);
      if (k == 8) check("ovf_not_yet", 32'(bus.overflow), 32'd0);
    end
    check("nest_out", 32'(bus.out),      32'h0A00);
    check("nest_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 0, 16'h0000); tick();
      check("unwind_out",   32'(bus.out),   32'h0901 - 32'(i) * 32'h100);
      check("unwind_depth", 32'(bus.depth), 32'(7 - i));
    end
    drive(0, 1, 0, 0, 0, 16'h0000); tick();
    check("ret9_out",   32'(bus.out),       32'h0201);
    check("ret9_unf",   32'(bus.underflow), 32'd1);
    check("ret9_depth", 32'(bus.depth),     32'd0);

    // clear_err racing a new underflow: error wins, overflow cleared
    drive(0, 1, 0, 0, 1, 16'h0000); tick();
    check("clr_race_unf", 32'(bus.underflow), 32'd1);
    check("clr_race_ovf", 32'(bus.overflow),  32'd0);
    drive(0, 0, 0, 0, 1, 16'h0000); tick();
    check("clr_unf", 32'(bus.underflow), 32'd0);
    check("clr_ovf", 32'(bus.overflow),  32'd0);

    // priority: call beats ret/load/inc; ret beats load
    drive(0, 0, 1, 0, 0, 16'h0005); tick();
    drive(1, 1, 1, 1, 0, 16'h0300); tick();
    check("prio_call_out",   32'(bus.out),   32'h0300);
    check("prio_call_depth", 32'(bus.depth), 32'd1);
    drive(0, 1, 1, 0, 0, 16'h0777); tick();
    check("prio_ret_out",   32'(bus.out),   32'h0006);
    check("prio_ret_depth", 32'(bus.depth), 32'd0);

    // return address wraps when calling from 0xFFFF
    drive(0, 0, 1, 0, 0, 16'hFFFF); tick();
    drive(1, 0, 0, 0, 0, 16'h0400); tick();
    check("wrap_call_out", 32'(bus.out), 32'h0400);
    drive(0, 1, 0, 0, 0, 16'h0000); tick();
    check("wrap_ret_out",   32'(bus.out),   32'h0000);
    check("wrap_ret_depth", 32'(bus.depth), 32'd0);
    check("wrap_ret_unf",   32'(bus.underflow), 32'd0);

    drive(0, 0, 0, 0, 0, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
